// File: rtl/clk_switch_seq_if.sv
// Request handshake into the clock-switch sequencer.
// master issues req_vld/req_sel, slave answers with req_rdy.
interface clk_switch_seq_if;
  logic req_vld;
  logic req_sel;
  logic req_rdy;

  modport master (
    output req_vld,
    output req_sel,
    input  req_rdy
  );

  modport slave (
    input  req_vld,
    input  req_sel,
    output req_rdy
  );
endinterface

// File: rtl/clk_switch_seq.sv
// Select sequencer for the glitch-free ref/PLL clock switch.
// CLK_SWITCH_SEQ_FALLBACK_EN adds automatic fallback to ref on lock loss.
module clk_switch_seq #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT       = 1024,
  parameter int SETTLE_CYCLES      = 8
) (
  input  logic              clk,
  input  logic              rst,
  clk_switch_seq_if.slave   req,
  input  logic              pll_lock,
  input  logic              err_clr,
  output logic              clk_sel,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              lock_lost
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int EW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [EW-1:0] SETTLE_END = EW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    SWITCH,
    SETTLE,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic          lock_meta, lock_sync;
  logic          target, target_nx;
  logic          fb_mode, fb_mode_nx;
  logic          clk_sel_nx;
  logic [SW-1:0] stable_cnt, stable_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [EW-1:0] settle_cnt, settle_nx;
  logic          set_tmo;
  logic          fallback_trig;
  logic          accept;

  assign req.req_rdy = (state == IDLE) & ~fallback_trig;
  assign accept      = req.req_vld & req.req_rdy;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    state_nx   = state;
    target_nx  = target;
    fb_mode_nx = fb_mode;
    clk_sel_nx = clk_sel;
    stable_nx  = stable_cnt;
    tmo_nx     = tmo_cnt;
    settle_nx  = settle_cnt;
    set_tmo    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fallback_trig) begin
          target_nx  = 1'b0;
          fb_mode_nx = 1'b1;
          state_nx   = SWITCH;
        end else if (accept) begin
          target_nx  = req.req_sel;
          fb_mode_nx = 1'b0;
          if (req.req_sel == clk_sel) begin
            state_nx = DONE;
          end else if (!req.req_sel) begin
            state_nx = SWITCH;
          end else begin
            stable_nx = '0;
            tmo_nx    = '0;
            state_nx  = WAIT_LOCK;
          end
        end
      end
      WAIT_LOCK: begin
        // lock win is checked first so it beats a same-cycle timeout
        if (stable_cnt == STABLE_MAX) begin
          state_nx = SWITCH;
        end else if (tmo_cnt == TMO_MAX) begin
          set_tmo  = 1'b1;
          state_nx = DONE;
        end else begin
          stable_nx = lock_sync ? stable_cnt + SW'(1) : '0;
          tmo_nx    = tmo_cnt + TW'(1);
        end
      end
      SWITCH: begin
        clk_sel_nx = target;
        settle_nx  = '0;
        state_nx   = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_END) begin
          state_nx = fb_mode ? IDLE : DONE;
        end else begin
          settle_nx = settle_cnt + EW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      fb_mode    <= 1'b0;
      clk_sel    <= 1'b0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      fb_mode    <= fb_mode_nx;
      clk_sel    <= clk_sel_nx;
      stable_cnt <= stable_nx;
      tmo_cnt    <= tmo_nx;
      settle_cnt <= settle_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (set_tmo) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

`ifdef CLK_SWITCH_SEQ_FALLBACK_EN
  logic lost_q;

  assign fallback_trig = (state == IDLE) & clk_sel & ~lock_sync;
  assign lock_lost     = lost_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q <= 1'b0;
    end else if (fallback_trig) begin
      lost_q <= 1'b1;
    end else if (err_clr) begin
      lost_q <= 1'b0;
    end
  end
`else
  assign fallback_trig = 1'b0;
  assign lock_lost     = 1'b0;
`endif

endmodule

// File: tb/tb_clk_switch_seq.sv
// Scoreboard bench for clk_switch_seq with a lock-pattern reference model.
// Fallback scenario runs only when CLK_SWITCH_SEQ_FALLBACK_EN is defined.
module tb_clk_switch_seq;

  localparam int L   = 16;
  localparam int T   = 1024;
  localparam int S   = 8;
  localparam int NTX = 24;
  localparam int NL  = 65536;

  typedef struct {
    int cyc;
    int sw;
    bit sel;
    bit tmo;
    bit lost;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock = 1'b1;
  logic err_clr = 1'b0;
  logic clk_sel, busy, done, err_timeout, lock_lost;

  clk_switch_seq_if req_if();

  clk_switch_seq #(
    .LOCK_STABLE_CYCLES(L),
    .LOCK_TIMEOUT(T),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req_if),
    .pll_lock(pll_lock),
    .err_clr(err_clr),
    .clk_sel(clk_sel),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   fb_sw = -1;
  bit   lockv [0:NL-1];
  bit   m_sel = 1'b0;
  bit   m_tmo = 1'b0;
  bit   m_lost = 1'b0;
  logic prev_sel = 1'b0;
  logic rst_q = 1'b1;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // pll_lock during cycle c is lockv[c]; the DUT sees it as lock_sync in c+2
  initial forever begin
    @(posedge clk);
    #1;
    pll_lock = lockv[cyc];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst && !rst_q) begin
      if (clk_sel !== prev_sel) begin
        if (fb_sw >= 0 && clk_sel === 1'b0) begin
          chk("fallback_sel_cycle", cyc, fb_sw);
          fb_sw = -1;
        end else if (expq.size() > 0) begin
          chk("sel_change_cycle", cyc, expq[0].sw);
        end else begin
          chk("unexpected_sel_change", clk_sel, prev_sel);
        end
      end
      if (done !== 1'b0) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          mon_e = expq.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("done_clk_sel", clk_sel, mon_e.sel);
          chk("done_err_timeout", err_timeout, mon_e.tmo);
          chk("done_lock_lost", lock_lost, mon_e.lost);
          chk("done_busy", busy, 1);
          chk("done_req_rdy", req_if.req_rdy, 0);
        end
      end
    end
    prev_sel = clk_sel;
    rst_q = rst;
  end

  // Request accepted in cycle a: a PLL win needs L consecutive high synced
  // samples inside the wait window, found at most T wait cycles in.
  function automatic exp_t predict(input int a, input bit tgt);
    exp_t e;
    int   win;
    bit   ok;
    e.sel  = m_sel;
    e.tmo  = m_tmo;
    e.lost = m_lost;
    e.sw   = -1;
    if (tgt == m_sel) begin
      e.cyc = a + 1;
    end else if (!tgt) begin
      e.sel = 1'b0;
      e.sw  = a + 2;
      e.cyc = a + 2 + S;
    end else begin
      win = -1;
      for (int j = L; j <= T && win < 0; j++) begin
        ok = 1'b1;
        for (int i = a - 1 + j - L; i <= a - 2 + j; i++) ok &= lockv[i];
        if (ok) win = j;
      end
      if (win >= 0) begin
        e.sel = 1'b1;
        e.sw  = a + 1 + win + 2;
        e.cyc = e.sw + S;
      end else begin
        e.tmo = 1'b1;
        e.cyc = a + 2 + T;
      end
    end
    return e;
  endfunction

  task automatic fill(input int a, input int mode, input int per);
    for (int i = a - 1; i < a + T + S + 80; i++) begin
      if (m_sel) lockv[i] = 1'b1;
      else begin
        case (mode)
          0: lockv[i] = 1'b1;
          1: lockv[i] = (((i - a + 1) / per) % 2) == 0;
          2: lockv[i] = ($urandom_range(0, 99) < 90);
          default: lockv[i] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic launch(input bit tgt, input int mode, input int per,
                        output int a, output exp_t e);
    @(posedge clk); #1;
    a = cyc + 2;
    fill(a, mode, per);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_if.req_vld = 1'b1;
    req_if.req_sel = tgt;
    e = predict(a, tgt);
    expq.push_back(e);
    if (e.sel && !m_sel)
      for (int i = e.sw - 1; i < a + T + S + 80; i++) lockv[i] = 1'b1;
    m_sel = e.sel;
    m_tmo = e.tmo;
    @(negedge clk);
    chk("req_rdy_idle", req_if.req_rdy, 1);
    @(posedge clk); #1;
    req_if.req_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (expq.size() > 0 && n < T + S + 60) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      chk("done_missing", expq.size(), 0);
      expq.delete();
    end
  endtask

  task automatic issue(input bit tgt, input int mode, input int per);
    int   a;
    exp_t e;
    launch(tgt, mode, per, a, e);
    wait_done();
  endtask

  task automatic clear_flags();
    @(posedge clk); #1;
    chk("err_timeout_sticky", err_timeout, m_tmo);
    chk("lock_lost_sticky", lock_lost, m_lost);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_tmo = 1'b0;
    m_lost = 1'b0;
    chk("err_timeout_cleared", err_timeout, 0);
    chk("lock_lost_cleared", lock_lost, 0);
  endtask

`ifdef CLK_SWITCH_SEQ_FALLBACK_EN
  task automatic fallback_test();
    int   c0;
    int   acc;
    exp_t e;
    if (!m_sel) issue(1'b1, 0, 0);
    @(posedge clk); #1;
    c0 = cyc + 1;
    for (int i = c0; i < c0 + 6; i++) lockv[i] = 1'b0;
    for (int i = c0 + 6; i < c0 + T + S + 100; i++) lockv[i] = 1'b1;
    fb_sw = c0 + 4;
    while (cyc < c0 + 2) begin
      @(posedge clk); #1;
    end
    req_if.req_vld = 1'b1;
    req_if.req_sel = 1'b1;
    @(negedge clk);
    chk("fallback_req_rdy_low", req_if.req_rdy, 0);
    @(negedge clk);
    chk("fallback_lock_lost", lock_lost, 1);
    chk("fallback_busy", busy, 1);
    m_sel = 1'b0;
    m_lost = 1'b1;
    acc = -1;
    for (int n = 0; n < 30 && acc < 0; n++) begin
      @(negedge clk);
      if (req_if.req_rdy === 1'b1) acc = cyc;
    end
    chk("fallback_accept_cycle", acc, c0 + 12);
    if (acc >= 0) begin
      e = predict(acc, 1'b1);
      expq.push_back(e);
      m_sel = e.sel;
      m_tmo = e.tmo;
    end
    @(posedge clk); #1;
    req_if.req_vld = 1'b0;
    wait_done();
    chk("fallback_sel_seen", fb_sw, -1);
  endtask
`endif

  task automatic reset_in_settle();
    int   a;
    exp_t e;
    if (m_sel) issue(1'b0, 0, 0);
    launch(1'b1, 0, 0, a, e);
    while (cyc < e.sw + 3) begin
      @(posedge clk); #1;
    end
    expq.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_sel = 1'b0;
    m_tmo = 1'b0;
    m_lost = 1'b0;
    @(negedge clk);
    chk("rst_mid_clk_sel", clk_sel, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_req_rdy", req_if.req_rdy, 1);
    repeat (S + 6) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit tgt;
    int mode;
    int per;
    for (int i = 0; i < NL; i++) lockv[i] = 1'b1;
    req_if.req_vld = 1'b0;
    req_if.req_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_clk_sel", clk_sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_timeout", err_timeout, 0);
    chk("reset_lock_lost", lock_lost, 0);
    chk("reset_req_rdy", req_if.req_rdy, 1);

    issue(1'b1, 0, 0);
    issue(1'b0, 0, 0);
    issue(1'b0, 0, 0);
    issue(1'b1, 1, 10);
    clear_flags();
`ifdef CLK_SWITCH_SEQ_FALLBACK_EN
    fallback_test();
    clear_flags();
`endif
    reset_in_settle();

    for (int k = 0; k < NTX; k++) begin
      tgt  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      per  = $urandom_range(2, 24);
      issue(tgt, mode, per);
      if ($urandom_range(0, 3) == 0) clear_flags();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
